// File: rtl/arb_mux_stream_if.sv
// ---------------------------------------------------------------------------
// arb_mux_stream_if
//   Bundles the N producer channels and the single consumer channel of
//   arb_mux_stream.
//   Signals:
//     in_data   [N*WIDTH] channel i occupies bits [i*WIDTH +: WIDTH]
//     in_valid  [N]       channel i holds a word
//     in_ready  [N]       channel i word accepted this cycle
//     sel_en              1 = forced-select mode
//     sel_in    [SW]      forced channel; values >= N select nothing
//     out_data  [WIDTH]   registered output word
//     out_sel   [SW]      index of the channel that produced out_data
//     out_valid           out_data valid
//     out_ready           consumer accepts when out_valid & out_ready
//   Modports: slave = the mux itself, master = the producers/consumer side.
// ---------------------------------------------------------------------------
interface arb_mux_stream_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned N     = 4
);
    localparam int unsigned SW = $clog2(N);

    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic               sel_en;
    logic [SW-1:0]      sel_in;
    logic [WIDTH-1:0]   out_data;
    logic [SW-1:0]      out_sel;
    logic               out_valid;
    logic               out_ready;

    modport slave (
        input  in_data, in_valid, sel_en, sel_in, out_ready,
        output in_ready, out_data, out_sel, out_valid
    );

    modport master (
        output in_data, in_valid, sel_en, sel_in, out_ready,
        input  in_ready, out_data, out_sel, out_valid
    );
endinterface

// File: rtl/arb_mux_stream.sv
// ---------------------------------------------------------------------------
// arb_mux_stream
//   N:1 datapath mux with a registered output stage and valid/ready
//   handshakes. With sel_en=1 only channel sel_in may be granted; with
//   sel_en=0 the valid channels are arbitrated either round-robin
//   (RR_MODE=1) or by fixed priority with channel 0 highest (RR_MODE=0).
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous, active-high reset
//     bus   arb_mux_stream_if.slave (producer inputs, registered output)
// ---------------------------------------------------------------------------
module arb_mux_stream #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N       = 4,
    parameter int unsigned RR_MODE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    arb_mux_stream_if.slave       bus
);
    localparam int unsigned SW = $clog2(N);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SW-1:0]    out_sel_q,   out_sel_d;
    logic             out_valid_q, out_valid_d;
    logic [SW-1:0]    ptr_q,       ptr_d;

    logic             load_ok;
    logic             grant_any;
    logic [SW-1:0]    grant_idx;
    logic [SW-1:0]    cand;
    logic [N-1:0]     grant;
    logic             accept;

    // The output register may take a new word when empty or draining.
    assign load_ok = !out_valid_q || bus.out_ready;

    // Winner search. The arbitration scan runs from the last candidate back
    // to the first so the earliest valid candidate in scan order is the one
    // left standing.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (bus.sel_en) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (bus.sel_in == SW'(i) && bus.in_valid[i]) begin
                    grant_any = 1'b1;
                    grant_idx = SW'(i);
                end
            end
        end else begin
            for (int unsigned k = N; k > 0; k--) begin
                if (RR_MODE != 0) begin
                    cand = SW'((32'(ptr_q) + k - 1) % N);
                end else begin
                    cand = SW'(k - 1);
                end
                if (bus.in_valid[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < N; i++) begin
            grant[i] = grant_any && (grant_idx == SW'(i));
        end
    end

    assign bus.in_ready = grant & {N{load_ok & ~rst}};
    assign accept       = grant_any && load_ok;

    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_data_d  = bus.in_data[32'(grant_idx) * WIDTH +: WIDTH];
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
            if (RR_MODE != 0) begin
                ptr_d = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;
            end
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_sel   = out_sel_q;
    assign bus.out_valid = out_valid_q;
endmodule
